// File: rtl/gpio_mmio_block.sv
// -----------------------------------------------------------------------------
// gpio_mmio_block
//
// Memory-mapped GPIO peripheral on the CPU data bus. Drives N_OUT output pins
// from a register, samples N_IN asynchronous input pins through a two-flop
// synchroniser and an optional per-pin debouncer, and flags enabled rising /
// falling edges in a sticky write-1-to-clear status register that feeds a
// maskable level interrupt.
//
// Register map (byte addresses, unused upper data bits read 0):
//   0x00 OUT       rw    output register, drives out_pins
//   0x04 IN        ro    debounced, synchronised input value
//   0x08 OUT_SET   wo    OUT |= wdata, reads 0
//   0x0C OUT_CLR   wo    OUT &= ~wdata, reads 0
//   0x10 EDGE_ST   rw1c  sticky edge flags, writing 1 clears a bit
//   0x14 IRQ_MASK  rw    per-pin interrupt enable
//   0x18 RISE_EN   rw    per-pin rising-edge capture enable
//   0x1C FALL_EN   rw    per-pin falling-edge capture enable
//   anything else: reads 0, writes ignored
//
// Bus handshake: write_en and read_en are single-cycle strobes with no
// back-pressure; the block always accepts. A write takes effect at the clock
// edge where write_en is high. A read samples the register selected by addr
// at the edge where read_en is high and presents it on read_data from the
// next cycle on, holding it until the next read. A simultaneous read and
// write of the same register returns the pre-write value.
//
// Ports:
//   clk         in   1       system clock, rising edge
//   reset       in   1       synchronous active-high reset
//   addr        in   ADDR_W  register byte address
//   write_data  in   DATA_W  write data
//   write_en    in   1       write strobe
//   read_en     in   1       read strobe
//   read_data   out  DATA_W  registered read data
//   in_pins     in   N_IN    asynchronous input pins
//   out_pins    out  N_OUT   output pins (OUT register)
//   irq         out  1       |(EDGE_ST & IRQ_MASK)
//
// N_IN and N_OUT must not exceed DATA_W; ADDR_W must be at least 5.
// -----------------------------------------------------------------------------
module gpio_mmio_block #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 4,
    parameter int DB_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    input  logic [N_IN-1:0]   in_pins,
    output logic [N_OUT-1:0]  out_pins,
    output logic              irq
);

    localparam logic [ADDR_W-1:0] A_OUT     = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_IN      = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_OUT_SET = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] A_OUT_CLR = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] A_EDGE_ST = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_IRQ_MSK = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] A_RISE_EN = ADDR_W'(8'h18);
    localparam logic [ADDR_W-1:0] A_FALL_EN = ADDR_W'(8'h1C);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [N_OUT-1:0]  out_q,      out_d;
    logic [N_IN-1:0]   edge_st_q,  edge_st_d;
    logic [N_IN-1:0]   irq_mask_q, irq_mask_d;
    logic [N_IN-1:0]   rise_en_q,  rise_en_d;
    logic [N_IN-1:0]   fall_en_q,  fall_en_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    // Input path: two-flop synchroniser, then the IN value (debounced or
    // straight from the synchroniser), then a one-cycle delayed copy of IN
    // used for edge detection.
    logic [N_IN-1:0] sync1_q;
    logic [N_IN-1:0] sync2_q;
    logic [N_IN-1:0] in_val;
    logic [N_IN-1:0] in_prev_q;

    // Data bits above the register width are ignored on writes.
    logic [N_OUT-1:0] wdata_out;
    logic [N_IN-1:0]  wdata_in;
    logic             unused_wdata;

    assign wdata_out    = write_data[N_OUT-1:0];
    assign wdata_in     = write_data[N_IN-1:0];
    assign unused_wdata = ^write_data;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_pins;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Debounce (or bypass when DB_CYC == 0)
    // ------------------------------------------------------------------
    generate
        if (DB_CYC == 0) begin : g_bypass
            assign in_val = sync2_q;
        end else begin : g_debounce
            localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

            logic [N_IN-1:0]  db_q, db_d;
            logic [CNT_W-1:0] cnt_q [N_IN];
            logic [CNT_W-1:0] cnt_d [N_IN];

            // A pin's counter runs only while the synchronised value differs
            // from the accepted IN value; any return to agreement restarts
            // it, so only a difference held for DB_CYC cycles is accepted.
            always_comb begin
                db_d = db_q;
                for (int i = 0; i < N_IN; i++) begin
                    cnt_d[i] = cnt_q[i];
                    if (sync2_q[i] == db_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]  = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    db_q <= '0;
                    for (int i = 0; i < N_IN; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    db_q <= db_d;
                    for (int i = 0; i < N_IN; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign in_val = db_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection on IN
    // ------------------------------------------------------------------
    logic [N_IN-1:0] edge_evt;

    assign edge_evt = (in_val & ~in_prev_q & rise_en_q)
                    | (~in_val & in_prev_q & fall_en_q);

    // ------------------------------------------------------------------
    // Read mux: always reflects register state before any same-cycle write
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_OUT:     rd_mux = DATA_W'(out_q);
            A_IN:      rd_mux = DATA_W'(in_val);
            A_EDGE_ST: rd_mux = DATA_W'(edge_st_q);
            A_IRQ_MSK: rd_mux = DATA_W'(irq_mask_q);
            A_RISE_EN: rd_mux = DATA_W'(rise_en_q);
            A_FALL_EN: rd_mux = DATA_W'(fall_en_q);
            default:   rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state for the bus-visible registers
    // ------------------------------------------------------------------
    logic [N_IN-1:0] w1c;

    always_comb begin
        out_d       = out_q;
        irq_mask_d  = irq_mask_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        w1c         = '0;
        read_data_d = read_en ? rd_mux : read_data_q;

        if (write_en) begin
            case (addr)
                A_OUT:     out_d      = wdata_out;
                A_OUT_SET: out_d      = out_q | wdata_out;
                A_OUT_CLR: out_d      = out_q & ~wdata_out;
                A_EDGE_ST: w1c        = wdata_in;
                A_IRQ_MSK: irq_mask_d = wdata_in;
                A_RISE_EN: rise_en_d  = wdata_in;
                A_FALL_EN: fall_en_d  = wdata_in;
                default:   ;
            endcase
        end

        // Clear first, then OR in new edges: a fresh edge on the same cycle
        // as its write-1-to-clear keeps the flag set.
        edge_st_d = (edge_st_q & ~w1c) | edge_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            edge_st_q   <= '0;
            irq_mask_q  <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            read_data_q <= '0;
            in_prev_q   <= '0;
        end else begin
            out_q       <= out_d;
            edge_st_q   <= edge_st_d;
            irq_mask_q  <= irq_mask_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            read_data_q <= read_data_d;
            in_prev_q   <= in_val;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign read_data = read_data_q;
    assign out_pins  = out_q;
    assign irq       = |(edge_st_q & irq_mask_q);

endmodule

// File: tb/tb_gpio_mmio_block.sv
module tb_gpio_mmio_block;

    // ------------------------------------------------------------------
    // Clock / reset and DUT wiring
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] write_data;
    logic       write_en;
    logic       read_en;
    logic [3:0] in_pins;

    logic [7:0] rd0, rd4;
    logic [3:0] out0, out4;
    logic       irq0, irq4;

    always #5 clk = ~clk;

    // Bypass instance and a DB_CYC=4 instance share the same bus and pins.
    gpio_mmio_block #(.ADDR_W(8), .DATA_W(8), .N_IN(4), .N_OUT(4), .DB_CYC(0)) dut0 (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .write_en(write_en), .read_en(read_en), .read_data(rd0),
        .in_pins(in_pins), .out_pins(out0), .irq(irq0)
    );

    gpio_mmio_block #(.ADDR_W(8), .DATA_W(8), .N_IN(4), .N_OUT(4), .DB_CYC(4)) dut4 (
        .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
        .write_en(write_en), .read_en(read_en), .read_data(rd4),
        .in_pins(in_pins), .out_pins(out4), .irq(irq4)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%02h required=%02h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Driver: inputs change 1 time unit after the rising edge, outputs
    // are sampled at the same point after the following edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic we, input logic re, input logic [3:0] p);
        reset      = r;
        addr       = a;
        write_data = d;
        write_en   = we;
        read_en    = re;
        in_pins    = p;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (bypass instance, one row per clock edge)
    // ------------------------------------------------------------------
    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] d;
        logic       we;
        logic       re;
        logic [3:0] pins;
        logic [3:0] e_out;
        logic       e_irq;
        logic [7:0] e_rd;
    } vec_t;

    localparam int NV = 42;
    vec_t tbl [NV];

    task automatic v(input int i, input logic r, input logic [7:0] a, input logic [7:0] d,
                     input logic we, input logic re, input logic [3:0] p,
                     input logic [3:0] eo, input logic ei, input logic [7:0] er);
        tbl[i] = '{r, a, d, we, re, p, eo, ei, er};
    endtask

    task automatic fill_table();
        // reset held two cycles against a write to OUT
        v( 0, 1, 8'h00, 8'hFF, 1, 0, 4'h0, 4'h0, 0, 8'h00);
        v( 1, 1, 8'h00, 8'hFF, 1, 0, 4'h0, 4'h0, 0, 8'h00);
        // OUT write, atomic set, atomic clear, read back
        v( 2, 0, 8'h00, 8'h0D, 1, 0, 4'h0, 4'hD, 0, 8'h00);
        v( 3, 0, 8'h08, 8'h02, 1, 0, 4'h0, 4'hF, 0, 8'h00);
        v( 4, 0, 8'h0C, 8'h05, 1, 0, 4'h0, 4'hA, 0, 8'h00);
        v( 5, 0, 8'h00, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h0A);
        // write-only and unmapped addresses read 0
        v( 6, 0, 8'h08, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h00);
        v( 7, 0, 8'h00, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h0A);
        v( 8, 0, 8'h0C, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h00);
        v( 9, 0, 8'h00, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h0A);
        v(10, 0, 8'h3C, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h00);
        // unmapped write changes nothing; read_data holds without read_en
        v(11, 0, 8'h3C, 8'hFF, 1, 0, 4'h0, 4'hA, 0, 8'h00);
        v(12, 0, 8'h00, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h0A);
        v(13, 0, 8'h14, 8'h00, 0, 1, 4'h0, 4'hA, 0, 8'h00);
        // rising-edge capture on pin0 with irq enabled, then W1C
        v(14, 0, 8'h18, 8'h01, 1, 0, 4'h0, 4'hA, 0, 8'h00);
        v(15, 0, 8'h14, 8'h01, 1, 0, 4'h0, 4'hA, 0, 8'h00);
        v(16, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'hA, 0, 8'h00);
        v(17, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'hA, 0, 8'h00);
        v(18, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'hA, 1, 8'h00);
        v(19, 0, 8'h10, 8'h00, 0, 1, 4'h1, 4'hA, 1, 8'h01);
        v(20, 0, 8'h10, 8'h01, 1, 0, 4'h1, 4'hA, 0, 8'h01);
        v(21, 0, 8'h10, 8'h00, 0, 1, 4'h1, 4'hA, 0, 8'h00);
        // read and write of OUT together: read sees the old value
        v(22, 0, 8'h00, 8'h05, 1, 1, 4'h1, 4'h5, 0, 8'h0A);
        v(23, 0, 8'h00, 8'h00, 0, 1, 4'h1, 4'h5, 0, 8'h05);
        // set a flag, then W1C on the same edge as a new rising edge
        v(24, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 0, 8'h05);
        v(25, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 0, 8'h05);
        v(26, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'h5, 0, 8'h05);
        v(27, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'h5, 0, 8'h05);
        v(28, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'h5, 1, 8'h05);
        v(29, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 1, 8'h05);
        v(30, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 1, 8'h05);
        v(31, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'h5, 1, 8'h05);
        v(32, 0, 8'h00, 8'h00, 0, 0, 4'h1, 4'h5, 1, 8'h05);
        v(33, 0, 8'h10, 8'h01, 1, 0, 4'h1, 4'h5, 1, 8'h05);
        v(34, 0, 8'h10, 8'h00, 0, 1, 4'h1, 4'h5, 1, 8'h01);
        v(35, 0, 8'h10, 8'h01, 1, 0, 4'h1, 4'h5, 0, 8'h01);
        // falling-edge capture, then masking keeps the flag
        v(36, 0, 8'h1C, 8'h01, 1, 0, 4'h1, 4'h5, 0, 8'h01);
        v(37, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 0, 8'h01);
        v(38, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 0, 8'h01);
        v(39, 0, 8'h00, 8'h00, 0, 0, 4'h0, 4'h5, 1, 8'h01);
        v(40, 0, 8'h14, 8'h00, 1, 0, 4'h0, 4'h5, 0, 8'h01);
        v(41, 0, 8'h10, 8'h00, 0, 1, 4'h0, 4'h5, 0, 8'h01);
    endtask

    // ------------------------------------------------------------------
    // Behavioural reference model of the bypass instance
    // ------------------------------------------------------------------
    logic [3:0] m_out, m_in, m_prev, m_edge, m_mask, m_rise, m_fall;
    logic [7:0] m_rd;
    logic [3:0] pin_dly [$];   // pins reach IN two edges after being driven

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            8'h00:   return {4'h0, m_out};
            8'h04:   return {4'h0, m_in};
            8'h10:   return {4'h0, m_edge};
            8'h14:   return {4'h0, m_mask};
            8'h18:   return {4'h0, m_rise};
            8'h1C:   return {4'h0, m_fall};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_in = 0; m_prev = 0; m_edge = 0;
        m_mask = 0; m_rise = 0; m_fall = 0; m_rd = 0;
        pin_dly.delete();
        pin_dly.push_back(4'h0);
    endtask

    task automatic model_step(input logic r, input logic [7:0] a, input logic [7:0] d,
                              input logic we, input logic re, input logic [3:0] p);
        logic [3:0] ev;
        logic [3:0] clr;
        if (r) begin
            model_reset();
            return;
        end
        if (re) m_rd = m_read(a);
        ev = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_in[i] && !m_prev[i] && m_rise[i]) ev[i] = 1'b1;
            if (!m_in[i] && m_prev[i] && m_fall[i]) ev[i] = 1'b1;
        end
        clr = 0;
        if (we) begin
            case (a)
                8'h00: m_out = d[3:0];
                8'h08: m_out = m_out | d[3:0];
                8'h0C: m_out = m_out & ~d[3:0];
                8'h10: clr   = d[3:0];
                8'h14: m_mask = d[3:0];
                8'h18: m_rise = d[3:0];
                8'h1C: m_fall = d[3:0];
                default: ;
            endcase
        end
        m_edge = (m_edge & ~clr) | ev;
        m_prev = m_in;
        pin_dly.push_back(p);
        m_in = pin_dly.pop_front();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] ra;
        logic [7:0] addr_list [8];
        logic       r, we, re;
        logic [7:0] d;
        logic [3:0] p;

        reset = 1'b1; addr = 0; write_data = 0; write_en = 0; read_en = 0; in_pins = 0;
        fill_table();

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            apply(tbl[i].rst, tbl[i].a, tbl[i].d, tbl[i].we, tbl[i].re, tbl[i].pins);
            chk($sformatf("row%0d out_pins", i), {4'h0, out0}, {4'h0, tbl[i].e_out});
            chk($sformatf("row%0d irq", i), {7'h0, irq0}, {7'h0, tbl[i].e_irq});
            chk($sformatf("row%0d read_data", i), rd0, tbl[i].e_rd);
            chk($sformatf("row%0d out_pins_db", i), {4'h0, out4}, {4'h0, tbl[i].e_out});
        end

        // ---- input latency: bypass 2 edges, DB_CYC=4 six edges ----
        apply(1, 8'h00, 8'h00, 0, 0, 4'h0);
        chk("reset rd_db", rd4, 8'h00);
        for (int k = 0; k < 8; k++) begin
            apply(0, 8'h04, 8'h00, 0, 1, 4'hA);
            chk($sformatf("in_lat_byp k%0d", k), rd0, (k >= 2) ? 8'h0A : 8'h00);
            chk($sformatf("in_lat_db k%0d", k), rd4, (k >= 6) ? 8'h0A : 8'h00);
        end

        // ---- 3-cycle glitch on pin0 is rejected by the debouncer ----
        for (int k = 0; k < 3; k++) apply(0, 8'h04, 8'h00, 0, 1, 4'hB);
        for (int k = 0; k < 10; k++) begin
            apply(0, 8'h04, 8'h00, 0, 1, 4'hA);
            chk($sformatf("glitch3 k%0d", k), rd4, 8'h0A);
        end

        // ---- 4-cycle pulse is accepted, then returns ----
        for (int k = 0; k < 4; k++) apply(0, 8'h04, 8'h00, 0, 1, 4'hB);
        for (int k = 0; k < 12; k++) begin
            apply(0, 8'h04, 8'h00, 0, 1, 4'hA);
            if (k == 2) chk("pulse4 accepted", rd4, 8'h0B);
        end
        chk("pulse4 settled", rd4, 8'h0A);

        // ---- reset in the middle of a debounce count ----
        for (int k = 0; k < 3; k++) apply(0, 8'h00, 8'h00, 0, 0, 4'h5);
        apply(1, 8'h04, 8'h00, 0, 1, 4'h5);
        chk("mid_db reset rd_db", rd4, 8'h00);
        chk("mid_db reset rd_byp", rd0, 8'h00);
        for (int k = 0; k < 7; k++) begin
            apply(0, 8'h04, 8'h00, 0, 1, 4'h5);
            chk($sformatf("mid_db k%0d", k), rd4, (k >= 6) ? 8'h05 : 8'h00);
            chk($sformatf("mid_db byp k%0d", k), rd0, (k >= 2) ? 8'h05 : 8'h00);
        end
        chk("irq_db after reset", {7'h0, irq4}, 8'h00);

        // ---- randomized traffic against the reference model ----
        addr_list = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
        apply(1, 8'h00, 8'h00, 0, 0, 4'h0);
        model_reset();
        p = 0;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            ra = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                             : addr_list[$urandom_range(0, 7)];
            d  = 8'($urandom);
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) p = 4'($urandom);
            apply(r, ra, d, we, re, p);
            model_step(r, ra, d, we, re, p);
            chk($sformatf("rand%0d out_pins", n), {4'h0, out0}, {4'h0, m_out});
            chk($sformatf("rand%0d irq", n), {7'h0, irq0}, {7'h0, |(m_edge & m_mask)});
            chk($sformatf("rand%0d read_data", n), rd0, m_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
